// File: rtl/bus_pkg.sv
// Shared bus-control definitions: select count, wait-field width, acknowledge FSM states
// and the lowest-index chip-select priority encoder.
package bus_pkg;

    localparam int NUM_SELECTS = 8;
    localparam int WAIT_BITS   = 4;
    localparam int SEL_BITS    = $clog2(NUM_SELECTS);

    // Widest select vector the priority encoder accepts; narrower vectors are zero-extended.
    localparam int MAX_SELECTS = 64;

    typedef logic [SEL_BITS-1:0] sel_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } bus_state_e;

    // Lowest set bit wins when the decoder asserts several selects at once.
    function automatic int lowest_set(input logic [MAX_SELECTS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_SELECTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with an asynchronous reset to a chosen value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments here so meta and q sample the pre-edge values; blocking
    // would collapse the two stages into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_ack_ctrl.sv
// 68000 bus acknowledge controller: per-select wait states, peripheral ready, DTACK/BERR.
// Define BUS_ACK_TIMEOUT_EN to turn hung WAIT cycles into a bus error after TIMEOUT_CYCLES.
module bus_ack_ctrl #(
    parameter int                                 NUM_SELECTS    = bus_pkg::NUM_SELECTS,
    parameter int                                 WAIT_BITS      = bus_pkg::WAIT_BITS,
    parameter logic [NUM_SELECTS*WAIT_BITS-1:0]   WAIT_STATES    = '0,
    parameter int                                 TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           as_n,
    input  logic [NUM_SELECTS-1:0]         cs,
    input  logic                           ready,
    output logic                           dtack_n,
    output logic                           berr_n,
    output logic [$clog2(NUM_SELECTS)-1:0] active_sel,
    output logic                           cycle_active
);

    import bus_pkg::*;

    localparam int SEL_W = $clog2(NUM_SELECTS);

    bus_state_e           state, next_state;
    logic [WAIT_BITS-1:0] wait_cnt, wait_next;
    logic [SEL_W-1:0]     sel_next;
    logic                 as_n_s, as_s;
    logic                 tmo_hit;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_as_sync (
        .clk (clk),
        .rst (rst),
        .d   (as_n),
        .q   (as_n_s)
    );

    assign as_s = ~as_n_s;

    logic [MAX_SELECTS-1:0] cs_wide;
    int                     pick_idx;
    logic [SEL_W-1:0]       pick_sel;
    logic [WAIT_BITS-1:0]   pick_wait;

    assign cs_wide  = MAX_SELECTS'(cs);
    assign pick_idx = lowest_set(cs_wide);
    assign pick_sel = SEL_W'(pick_idx);

    always_comb begin
        pick_wait = '0;
        for (int i = 0; i < NUM_SELECTS; i++) begin
            if (pick_sel == SEL_W'(i)) begin
                pick_wait = WAIT_STATES[i*WAIT_BITS +: WAIT_BITS];
            end
        end
    end

`ifdef BUS_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case so that no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        wait_next  = wait_cnt;
        sel_next   = active_sel;

        unique case (state)
            IDLE: begin
                if (as_s) begin
                    if (cs != '0) begin
                        next_state = WAIT;
                        sel_next   = pick_sel;
                        wait_next  = pick_wait;
                    end else begin
                        next_state = BERR;
                    end
                end
            end
            WAIT: begin
                // An aborted strobe wins, then completion, then the hang timeout.
                if (!as_s) begin
                    next_state = IDLE;
                end else if (wait_cnt == '0 && ready) begin
                    next_state = ACK;
                end else if (tmo_hit) begin
                    next_state = BERR;
                end else if (wait_cnt != '0) begin
                    wait_next = wait_cnt - 1'b1;
                end
            end
            ACK, BERR: begin
                if (!as_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            active_sel   <= '0;
            dtack_n      <= 1'b1;
            berr_n       <= 1'b1;
            cycle_active <= 1'b0;
        end else begin
            state        <= next_state;
            wait_cnt     <= wait_next;
            active_sel   <= sel_next;
            dtack_n      <= (next_state != ACK);
            berr_n       <= (next_state != BERR);
            cycle_active <= (next_state == WAIT) || (next_state == ACK);
        end
    end

    dtack_berr_exclusive: assert property (@(posedge clk) disable iff (rst) dtack_n || berr_n);

endmodule

// File: doc/bus_ack_ctrl.md
Name: bus_ack_ctrl

Overview:
- Downstream of the address chip-select decoder.
- Consumes its one-hot `cs` vector together with the 68000 address strobe.
- Runs the per-cycle acknowledge state machine:
  - counts per-select wait states;
  - honours a peripheral ready;
  - drives `dtack_n` back to the CPU, or `berr_n` for unmapped or hung accesses.
- Sits between the CPU bus pins and the peripheral/memory selects.

Parameters:
NUM_SELECTS, 8, number of chip-select lines; must match the decoder.
WAIT_BITS, 4, width of each wait-state field.
WAIT_STATES, {NUM_SELECTS*WAIT_BITS{1'b0}}, packed per-select wait counts; field i is bits [i*WAIT_BITS +: WAIT_BITS].
TIMEOUT_CYCLES, 256, bus-timeout limit in clk cycles (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
as_n  in  1  CPU address strobe, active-low, asynchronous to clk
cs  in  NUM_SELECTS  one-hot chip selects from the decoder (combinational from the address)
ready  in  1  peripheral ready; high = may complete; tie high if unused
dtack_n  out  1  data transfer acknowledge to CPU, active-low
berr_n  out  1  bus error to CPU, active-low
active_sel  out  $clog2(NUM_SELECTS)  index of the select latched for the current cycle
cycle_active  out  1  high from cycle latch until release

Behaviour:
- Reset (async, immediate): state=IDLE; dtack_n=1, berr_n=1, active_sel=0, cycle_active=0; synchroniser flops=1 (strobe negated); wait counter=0.
- as_n passes through a 2-flop synchroniser to give as_s (active-high internally). A falling edge of as_n is seen by the FSM 2 clk later.
- States and transitions:
  - IDLE:
    - as_s=1 and cs!=0 → latch the lowest-index set bit of cs into active_sel; load the counter with WAIT_STATES[active_sel]; cycle_active=1; go to WAIT.
    - as_s=1 and cs==0 → go to BERR.
  - WAIT:
    - counter!=0 → decrement.
    - counter==0 and ready=1 → go to ACK.
    - counter==0 and ready=0 → hold.
  - ACK: dtack_n=0, asserted on the first cycle in ACK; hold until as_s=0, then go to IDLE. dtack_n=1 and cycle_active=0 in the IDLE cycle.
  - BERR: berr_n=0; hold until as_s=0, then go to IDLE.
- Latency, first cycle with as_s=1 to dtack_n low: 1 + N clk, with N = wait field and ready high. N=0 gives dtack one clk after latch.
- Multiple cs bits set: the lowest index wins; no error.
- as_s drops in WAIT (aborted cycle): go to IDLE next clk; dtack_n and berr_n stay high; cycle_active clears.
- cs changing after latch is ignored until the next IDLE.
- Back-to-back cycles: as_s must be seen low for at least 1 clk in IDLE before a new latch. No re-latch while as_s stays high after ACK/BERR.
- dtack_n and berr_n are registered outputs, never both low.
- Counter width is WAIT_BITS, with no wrap: the decrement saturates at 0.

Optional Feature:
- Macro: BUS_ACK_TIMEOUT_EN.
- Defined:
  - A timeout counter of $clog2(TIMEOUT_CYCLES)+1 bits clears in IDLE and increments every clk in WAIT.
  - On reaching TIMEOUT_CYCLES-1 without entering ACK, the FSM goes to BERR (berr_n=0 next clk).
  - ACK takes priority if ready rises in the same cycle the limit is reached.
- Undefined: no timeout counter; WAIT holds indefinitely while ready=0. Unmapped (cs==0) accesses still produce BERR.

Decomposition:
- Shared package `bus_pkg`:
  - state enum (IDLE, WAIT, ACK, BERR);
  - NUM_SELECTS default;
  - select-index typedef;
  - WAIT_BITS.
- The chip-select decoder uses the same NUM_SELECTS from `bus_pkg`.
- Sub-module `sync_2ff`: generic 2-flop synchroniser with async reset-to-value parameter, instanced for as_n.
- Priority encoder: a function in the package, not a module.

Test Plan:
1. NUM_SELECTS=8, all waits 0, ready=1, cs=8'h04, as_n falls → active_sel=2; dtack_n low 4 clk after the as_n edge; releases 1 clk after as_s drops.
2. WAIT_STATES field 5 = 3, cs=8'h20 → dtack_n low 3 clk later than scenario 1; berr_n stays 1.
3. cs=8'h00 with as_n low → berr_n low 3 clk after the edge, dtack_n stays 1; both high after as_n rises.
4. cs=8'h0A (bits 1 and 3) → active_sel=1 and wait field 1 used.
5. Field 0 = 15, as_n rises after 5 clk in WAIT → no dtack/berr, cycle_active=0. Then rst pulsed mid-WAIT on a second cycle → all outputs return to reset values immediately.
6. With BUS_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16, ready=0 → berr_n low after 16 WAIT cycles. Without the macro: no berr for 1000 clk; ready=1 then gives dtack.
